// File: rtl/tile_pass_scheduler_if.sv
// Engine, VGA write-port and game-FSM signals of tile_pass_scheduler.
// engine_timeout exists only when TPS_WATCHDOG_EN is defined.
interface tile_pass_scheduler_if #(
  parameter int unsigned NUM_LINES = 6,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8
);
  logic                     frame_go;
  logic [NUM_LINES-1:0]     erase_done;
  logic [NUM_LINES-1:0]     draw_done;
  logic [NUM_LINES*X_W-1:0] erase_x;
  logic [NUM_LINES*Y_W-1:0] erase_y;
  logic [NUM_LINES-1:0]     erase_colour;
  logic [NUM_LINES*X_W-1:0] draw_x;
  logic [NUM_LINES*Y_W-1:0] draw_y;
  logic [NUM_LINES-1:0]     draw_colour;

  logic [NUM_LINES-1:0]     erase_enable;
  logic [NUM_LINES-1:0]     draw_enable;
  logic [X_W-1:0]           x_out;
  logic [Y_W-1:0]           y_out;
  logic [2:0]               colour_out;
  logic                     vga_enable;
  logic                     busy;
  logic                     pass_done;
  logic                     frame_overrun;
`ifdef TPS_WATCHDOG_EN
  logic                     engine_timeout;
`endif

  // Scheduler side
  modport master (
    input  frame_go, erase_done, draw_done,
    input  erase_x, erase_y, erase_colour,
    input  draw_x, draw_y, draw_colour,
    output erase_enable, draw_enable,
    output x_out, y_out, colour_out, vga_enable,
    output busy, pass_done, frame_overrun
`ifdef TPS_WATCHDOG_EN
    , output engine_timeout
`endif
  );

  // Engines, VGA port and game FSM side
  modport slave (
    output frame_go, erase_done, draw_done,
    output erase_x, erase_y, erase_colour,
    output draw_x, draw_y, draw_colour,
    input  erase_enable, draw_enable,
    input  x_out, y_out, colour_out, vga_enable,
    input  busy, pass_done, frame_overrun
`ifdef TPS_WATCHDOG_EN
    , input engine_timeout
`endif
  );
endinterface

// File: rtl/tile_pass_scheduler.sv
// Runs one refresh pass: every erase engine in turn, then every draw engine, muxing the active
// engine's pixel stream onto the VGA port. Define TPS_WATCHDOG_EN for a per-engine timeout.
module tile_pass_scheduler #(
  parameter int unsigned NUM_LINES = 6,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8,
  parameter logic [2:0]  FG_COLOUR = 3'b000,
  parameter logic [2:0]  BG_COLOUR = 3'b111
`ifdef TPS_WATCHDOG_EN
  , parameter int unsigned TIMEOUT = 4096
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  tile_pass_scheduler_if.master bus
);

  localparam int unsigned IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    ERASE_GAP,
    DRAW,
    DRAW_GAP,
    FINISH
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;

  logic               eng_active_c;
  logic               sel_done_c;
  logic [X_W-1:0]     sel_x_c;
  logic [Y_W-1:0]     sel_y_c;
  logic               sel_colour_c;
  logic               advance_c;
  logic               pixel_wr_c;

  logic [NUM_LINES-1:0] erase_enable_nx, draw_enable_nx;
  logic                 busy_nx, pass_done_nx, overrun_nx;

  logic [NUM_LINES-1:0] erase_enable_q, draw_enable_q;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [2:0]           colour_q;
  logic                 vga_q, busy_q, pass_done_q, overrun_q;

  // Select the active engine's done bit and pixel bus
  always_comb begin
    eng_active_c = (state == ERASE) || (state == DRAW);
    if (state == DRAW) begin
      sel_done_c   = bus.draw_done[idx];
      sel_x_c      = bus.draw_x[idx*X_W +: X_W];
      sel_y_c      = bus.draw_y[idx*Y_W +: Y_W];
      sel_colour_c = bus.draw_colour[idx];
    end else begin
      sel_done_c   = bus.erase_done[idx];
      sel_x_c      = bus.erase_x[idx*X_W +: X_W];
      sel_y_c      = bus.erase_y[idx*Y_W +: Y_W];
      sel_colour_c = bus.erase_colour[idx];
    end
    pixel_wr_c = eng_active_c && !sel_done_c;
  end

`ifdef TPS_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit_c;
  logic            timeout_q;

  assign wd_hit_c  = eng_active_c && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign advance_c = eng_active_c && (sel_done_c || wd_hit_c);

  // Counter is held at zero outside ERASE/DRAW, so it restarts for every engine
  always_ff @(posedge clock) begin
    if (reset || !eng_active_c) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_hit_c && !sel_done_c;
    end
  end

  assign bus.engine_timeout = timeout_q;
`else
  assign advance_c = eng_active_c && sel_done_c;
`endif

  // Next state plus next values of the registered outputs
  always_comb begin
    state_nx = state;
    idx_nx   = idx;

    case (state)
      IDLE: begin
        if (bus.frame_go) begin
          state_nx = ERASE;
          idx_nx   = '0;
        end
      end
      ERASE: begin
        if (advance_c) state_nx = ERASE_GAP;
      end
      ERASE_GAP: begin
        if (idx == LAST_IDX) begin
          state_nx = DRAW;
          idx_nx   = '0;
        end else begin
          state_nx = ERASE;
          idx_nx   = idx + 1'b1;
        end
      end
      DRAW: begin
        if (advance_c) state_nx = DRAW_GAP;
      end
      DRAW_GAP: begin
        if (idx == LAST_IDX) begin
          state_nx = FINISH;
          idx_nx   = '0;
        end else begin
          state_nx = DRAW;
          idx_nx   = idx + 1'b1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase

    erase_enable_nx = (state_nx == ERASE) ? (NUM_LINES'(1) << idx_nx) : '0;
    draw_enable_nx  = (state_nx == DRAW)  ? (NUM_LINES'(1) << idx_nx) : '0;
    busy_nx         = state_nx inside {ERASE, ERASE_GAP, DRAW, DRAW_GAP};
    pass_done_nx    = (state_nx == FINISH);
    overrun_nx      = bus.frame_go && (state != IDLE);
  end

  // State and output registers; pixel fields hold when no write is issued
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      erase_enable_q <= '0;
      draw_enable_q  <= '0;
      busy_q         <= 1'b0;
      pass_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      vga_q          <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      colour_q       <= BG_COLOUR;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      erase_enable_q <= erase_enable_nx;
      draw_enable_q  <= draw_enable_nx;
      busy_q         <= busy_nx;
      pass_done_q    <= pass_done_nx;
      overrun_q      <= overrun_nx;
      vga_q          <= pixel_wr_c;
      if (pixel_wr_c) begin
        x_q      <= sel_x_c;
        y_q      <= sel_y_c;
        colour_q <= sel_colour_c ? FG_COLOUR : BG_COLOUR;
      end
    end
  end

  assign bus.erase_enable  = erase_enable_q;
  assign bus.draw_enable   = draw_enable_q;
  assign bus.x_out         = x_q;
  assign bus.y_out         = y_q;
  assign bus.colour_out    = colour_q;
  assign bus.vga_enable    = vga_q;
  assign bus.busy          = busy_q;
  assign bus.pass_done     = pass_done_q;
  assign bus.frame_overrun = overrun_q;

endmodule

// File: doc/tile_pass_scheduler.md
Name: tile_pass_scheduler

Overview:
Sequences one screen refresh pass over the per-line erase and draw engines of the tile renderer. On each frame_go pulse it runs every erase engine in turn, then every draw engine in turn, one at a time. It steers the active engine's pixel stream onto the single VGA write port and reports pass completion to the game FSM.

Parameters:
NUM_LINES, 6, number of line engines per kind (erase and draw)
X_W, 9, pixel x width (0..319)
Y_W, 8, pixel y width (0..239)
FG_COLOUR, 3'b000, colour_out value when engine colour bit = 1
BG_COLOUR, 3'b111, colour_out value when engine colour bit = 0
TIMEOUT, 4096, watchdog limit in cycles per engine (used only with TPS_WATCHDOG_EN)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
frame_go  in  1  one-cycle pulse that starts a pass
erase_done  in  NUM_LINES  per-engine done, bit k from erase engine k
draw_done  in  NUM_LINES  per-engine done, bit k from draw engine k
erase_x  in  NUM_LINES*X_W  packed x buses, engine k at [k*X_W +: X_W]
erase_y  in  NUM_LINES*Y_W  packed y buses
erase_colour  in  NUM_LINES  per-engine colour bit
draw_x  in  NUM_LINES*X_W  packed x buses
draw_y  in  NUM_LINES*Y_W  packed y buses
draw_colour  in  NUM_LINES  per-engine colour bit
erase_enable  out  NUM_LINES  one-hot-or-zero engine enable
draw_enable  out  NUM_LINES  one-hot-or-zero engine enable
x_out  out  X_W  VGA write x
y_out  out  Y_W  VGA write y
colour_out  out  3  VGA write colour
vga_enable  out  1  VGA write strobe
busy  out  1  high from the cycle after frame_go is accepted until pass_done
pass_done  out  1  one-cycle pulse when the pass completes
frame_overrun  out  1  one-cycle pulse when frame_go arrives while busy

Behaviour:
- Reset, and every output after reset: all 0. Exceptions: colour_out = BG_COLOUR and state = IDLE. Index counter = 0. Reset wins over any in-flight pass. All enables drop at the next edge. No pass_done is produced.
- States: IDLE, ERASE, ERASE_GAP, DRAW, DRAW_GAP, FINISH.
- IDLE: when frame_go = 1, go to ERASE with idx = 0 and busy = 1 at the next edge.
- ERASE: erase_enable = (1 << idx), registered. When erase_done[idx] = 1 is sampled, go to ERASE_GAP. Done bits of non-selected engines are ignored.
- ERASE_GAP: exactly one cycle with all enables 0, so the engine can self-clear. Then:
  - if idx < NUM_LINES-1: idx+1, go to ERASE;
  - else: idx = 0, go to DRAW.
- DRAW and DRAW_GAP: identical to ERASE and ERASE_GAP, using the draw_* signals. The last DRAW_GAP goes to FINISH.
- FINISH: pass_done = 1 and busy = 0 for one cycle, then IDLE.
- An engine that asserts done on the first enabled cycle is legal: one ERASE or DRAW cycle followed by the gap.
- Pixel path: 1-cycle registered latency. In ERASE/DRAW, if the selected engine's done = 0:
  - x_out / y_out = selected engine's bus slice;
  - colour_out = colour bit ? FG_COLOUR : BG_COLOUR;
  - vga_enable = 1.
- In every other case, vga_enable = 0 and x/y/colour hold their last values.
- frame_go while busy or in FINISH is ignored; frame_overrun pulses for 1 cycle. frame_go in IDLE on the same cycle as reset is ignored.
- Ordering is fixed: all erases ascending 0..NUM_LINES-1, then all draws ascending. Never more than one enable bit high across both vectors.
- Minimum pass length, all engines done immediately: 1 + NUM_LINES*2*2 + 1 cycles from frame_go to pass_done, which is 26 for NUM_LINES = 6.

Optional Feature:
TPS_WATCHDOG_EN:
- Defined: a per-engine cycle counter clears on entry to ERASE/DRAW. If it reaches TIMEOUT-1 without done, the scheduler behaves as if done were sampled: it goes to the gap and pulses an extra output port, engine_timeout (1 bit), for one cycle.
- Not defined: no counter and no engine_timeout port; the scheduler waits indefinitely for done.

Test Plan:
1. reset = 1 for 3 cycles, then frame_go → all outputs 0 except colour_out = 3'b111; first frame_go gives busy = 1 on the next cycle.
2. All 12 engine models assert done after 4 enabled cycles → enable order erase0..5 then draw0..5, one-cycle zero gap between engines, vga_enable high 4 cycles per engine minus final done cycle, pass_done after 1+12*(4+1)+1 cycles.
3. Draw engine 2 drives x = 9'd160, y = 8'd200, colour = 1 → next cycle x_out = 160, y_out = 200, colour_out = 3'b000, vga_enable = 1.
4. frame_go pulsed during DRAW of line 3 → frame_overrun = 1 for one cycle; the sequence is unaffected; exactly one pass_done.
5. reset asserted during ERASE of line 4 → next cycle all enables 0, busy = 0, no pass_done; a new frame_go restarts at erase0.
6. TPS_WATCHDOG_EN with TIMEOUT = 16, erase engine 1 never asserts done → engine_timeout pulses after 16 enabled cycles; the scheduler proceeds to erase2 and completes the pass.
